// File: rtl/if_fetch_queue_if.sv
// Purpose : bundles the fetch-queue handshake, redirect and inst-SRAM signals.
// Latency : n/a. This file only groups signals.
// Backpr. : ds_allow_in is the ID-side ready. stall gates SRAM issue only.
//
// Ports (master = fetch queue side):
//   stall, br_taken, br_target, inst_sram_rdata, ds_allow_in   -> into the fetch queue
//   inst_sram_en, inst_sram_addr, fs_valid, fs_pc, fs_inst,
//   fs_count                                                    -> out of the fetch queue
interface if_fetch_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 3
);
    logic              stall;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              inst_sram_en;
    logic [PC_W-1:0]   inst_sram_addr;
    logic [INST_W-1:0] inst_sram_rdata;
    logic              ds_allow_in;
    logic              fs_valid;
    logic [PC_W-1:0]   fs_pc;
    logic [INST_W-1:0] fs_inst;
    logic [CNT_W-1:0]  fs_count;

    modport master (
        input  stall,
        input  br_taken,
        input  br_target,
        input  inst_sram_rdata,
        input  ds_allow_in,
        output inst_sram_en,
        output inst_sram_addr,
        output fs_valid,
        output fs_pc,
        output fs_inst,
        output fs_count
    );

    modport slave (
        output stall,
        output br_taken,
        output br_target,
        output inst_sram_rdata,
        output ds_allow_in,
        input  inst_sram_en,
        input  inst_sram_addr,
        input  fs_valid,
        input  fs_pc,
        input  fs_inst,
        input  fs_count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Purpose : sequential-PC fetch stage that decouples the inst SRAM from ID through a DEPTH-entry queue.
// Latency : an issue in cycle n is visible at the queue head in cycle n+2 when the queue was empty. Throughput is 1/cycle.
// Backpr. : issue is credit-gated (queued + in-flight <= DEPTH). ID backpressure via ds_allow_in. A redirect flushes everything.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous, active-high. Clears all state and forces inst_sram_en low.
//   fq       : if_fetch_queue_if.master. Carries the stall/redirect inputs, the inst SRAM
//              request/return and the ID-facing head entry plus occupancy.
module if_fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    if_fetch_queue_if.master fq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0]   r_fetch_pc;    // next sequential address to request
    logic [PC_W-1:0]   r_issue_pc;    // PC of the read currently in flight
    logic              r_inflight;    // a read was issued last cycle
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [CNT_W:0]    w_used;
    logic              w_has_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    // Queued entries plus the read in flight. Keeping this <= DEPTH means a
    // returning read always has a free slot, so the SRAM never needs a hold.
    assign w_used       = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
    assign w_has_credit = w_used < (CNT_W+1)'(DEPTH);

    // Reset is folded in so the request drops the moment reset asserts,
    // instead of waiting for the registered state to settle.
    assign w_issue = !i_reset && !fq.stall && !fq.br_taken && w_has_credit;

    assign w_valid = (r_count != '0);

    // A redirect kills both the returning (wrong-path) data and the head
    // shown this cycle, even if ID was ready to take it.
    assign w_push = r_inflight && !fq.br_taken;
    assign w_pop  = w_valid && fq.ds_allow_in && !fq.br_taken;

    // ------------------------------------------------------------------
    // Fetch PC and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
        end else if (fq.br_taken) begin
            r_fetch_pc <= fq.br_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issue_pc <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + PC_W'(4);
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (fq.br_taken) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage. Entry contents need no reset because the outputs are
    // masked to zero whenever the queue is empty.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset) begin
            r_mem_pc[r_wr_ptr]   <= r_issue_pc;
            r_mem_inst[r_wr_ptr] <= fq.inst_sram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fq.inst_sram_en   = w_issue;
    assign fq.inst_sram_addr = r_fetch_pc;
    assign fq.fs_valid       = w_valid;
    assign fq.fs_pc          = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign fq.fs_inst        = w_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign fq.fs_count       = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic clk;
    logic rst;

    if_fetch_queue_if #(.PC_W(32), .INST_W(32), .CNT_W(CNT_W)) fq ();

    if_fetch_queue #(
        .DEPTH   (DEPTH),
        .PC_W    (32),
        .INST_W  (32),
        .RESET_PC(RESET_PC)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .fq     (fq.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc,inst} entries plus one outstanding read.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic        m_prev_en;
    logic [31:0] m_prev_data;

    task automatic model_reset();
        mq.delete();
        m_fpc     = RESET_PC;
        m_infl    = 1'b0;
        m_infl_pc = '0;
        m_prev_en = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check the outputs, then advance the model.
    task automatic step(input logic r, input logic st, input logic br,
                        input logic [31:0] tgt, input logic allow);
        logic        exp_en;
        logic [31:0] rd;
        ent_t        e;
        @(negedge clk);
        rst               = r;
        fq.stall          = st;
        fq.br_taken       = br;
        fq.br_target      = tgt;
        fq.ds_allow_in    = allow;
        rd                = m_prev_en ? m_prev_data : $urandom;
        fq.inst_sram_rdata = rd;
        #1;
        if (r) begin
            model_reset();
            chk("rst_en",    {63'd0, fq.inst_sram_en}, 64'd0);
            chk("rst_valid", {63'd0, fq.fs_valid},     64'd0);
            chk("rst_count", {{(64-CNT_W){1'b0}}, fq.fs_count}, 64'd0);
            chk("rst_pc",    {32'd0, fq.fs_pc},        64'd0);
        end else begin
            exp_en = !st && !br && ((mq.size() + (m_infl ? 1 : 0)) < DEPTH);
            chk("en", {63'd0, fq.inst_sram_en}, {63'd0, exp_en});
            if (exp_en) chk("addr", {32'd0, fq.inst_sram_addr}, {32'd0, m_fpc});
            chk("valid", {63'd0, fq.fs_valid}, {63'd0, mq.size() != 0});
            chk("head_pc",   {32'd0, fq.fs_pc},   {32'd0, (mq.size() != 0) ? mq[0].pc   : 32'd0});
            chk("head_inst", {32'd0, fq.fs_inst}, {32'd0, (mq.size() != 0) ? mq[0].inst : 32'd0});
            chk("count", {{(64-CNT_W){1'b0}}, fq.fs_count}, 64'(mq.size()));
            if (br) begin
                mq.delete();
                m_infl = 1'b0;
                m_fpc  = tgt;
            end else begin
                if (mq.size() != 0 && allow) void'(mq.pop_front());
                if (m_infl) begin
                    e.pc   = m_infl_pc;
                    e.inst = rd;
                    mq.push_back(e);
                end
                m_infl = exp_en;
                if (exp_en) begin
                    m_infl_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end
            end
            m_prev_en   = exp_en;
            m_prev_data = $urandom;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        fq.stall = 1'b0;
        fq.br_taken = 1'b0;
        fq.br_target = '0;
        fq.ds_allow_in = 1'b0;
        fq.inst_sram_rdata = '0;
        model_reset();

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

        // Free flow from reset: sequential PCs, one per cycle.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // ID blocked: occupancy saturates and issue stops.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("sat_count", {{(64-CNT_W){1'b0}}, fq.fs_count}, 64'(DEPTH));
        chk("sat_en",    {63'd0, fq.inst_sram_en}, 64'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Build up entries with a read in flight, then redirect.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h1c000100, 1'b1);
        chk("br_flush", {63'd0, fq.fs_valid}, 64'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("br_valid", {63'd0, fq.fs_valid}, 64'd0);
        chk("br_addr",  {32'd0, fq.inst_sram_addr}, {32'd0, 32'h1c000100});
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Stall with a non-empty queue: pops continue, no issue.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'b0,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0),
                 {$urandom_range(0, 32'h0fffffff), 2'b00} | 32'h10000000,
                 ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset mid-stream, then resume from RESET_PC.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("post_rst_addr", {32'd0, fq.inst_sram_addr}, {32'd0, RESET_PC});
        for (int i = 0; i < 300; i++) begin
            step(1'b0,
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 15) == 0),
                 {$urandom_range(0, 32'h0fffffff), 2'b00},
                 ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
